// File: rtl/data_sram_if.sv
// Data-SRAM access bus: request fields driven by the initiator, registered
// read data and range-error flag returned by the memory.
//   data_sram_en     access request this cycle
//   data_sram_wen    byte-lane write enables (0 with en=1 is a read)
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  lane-aligned write data
//   data_sram_rdata  registered read data
//   data_sram_err    registered out-of-range flag for the previous access
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_err;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  data_sram_err
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output data_sram_err
    );
endinterface

// File: rtl/data_sram.sv
// Single-port word-organised data SRAM with byte-lane writes, write-first
// one-cycle read latency and an out-of-range error flag.
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset (clears rdata/err, not the array)
//   bus   data_sram_if.slave access bus
// Optional feature: define DATA_SRAM_MMIO_EN to add an MMIO page at
// 0x1FFFF000 with a free-running CYCLE counter (0x000) and a SCRATCH
// register (0x004); without it that page is just out of range.
module data_sram #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    data_sram_if.slave  bus
);
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned HI_LSB    = ADDR_WIDTH + 2;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_mmio_hit;
    logic [31:0]           w_mmio_rdata;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic                  w_mem_wr;
    logic                  w_unused;

    // Address decode: word index and upper-bit range check
    assign w_idx      = bus.data_sram_addr[ADDR_WIDTH+1:2];
    assign w_in_range = (bus.data_sram_addr >> HI_LSB) == 32'd0;
    assign w_old      = r_mem[w_idx];
    assign w_unused   = &{1'b0, bus.data_sram_addr[1:0]};

    // Lane merge gives the post-write word, used for both the array and rdata
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (bus.data_sram_wen[i]) begin
                w_merged[8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    // MMIO page takes precedence over the array range check
    assign w_mem_wr = bus.data_sram_en && w_in_range && !w_mmio_hit
                      && (bus.data_sram_wen != 4'b0000);

    // Array storage: not reset, but no write happens while rst is held low
    always_ff @(posedge clk) begin
        if (rst && w_mem_wr) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifdef DATA_SRAM_MMIO_EN
    logic [31:0] r_cycle;
    logic [31:0] r_scratch;
    logic [9:0]  w_mmio_off;
    logic [31:0] w_scratch_merged;

    assign w_mmio_hit = bus.data_sram_addr[31:12] == 20'h1FFFF;
    assign w_mmio_off = bus.data_sram_addr[11:2];

    // SCRATCH lane merge, write-first like the array
    always_comb begin
        w_scratch_merged = r_scratch;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (bus.data_sram_wen[i]) begin
                w_scratch_merged[8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    // CYCLE returns the pre-increment value; unmapped offsets read zero
    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_mmio_off)
            10'd0:   w_mmio_rdata = r_cycle;
            10'd1:   w_mmio_rdata = w_scratch_merged;
            default: w_mmio_rdata = 32'd0;
        endcase
    end

    // MMIO registers: free-running counter and byte-writable scratch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle   <= 32'd0;
            r_scratch <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (bus.data_sram_en && w_mmio_hit && (w_mmio_off == 10'd1)) begin
                r_scratch <= w_scratch_merged;
            end
        end
    end
`else
    assign w_mmio_hit   = 1'b0;
    assign w_mmio_rdata = 32'd0;
`endif

    // Response registers: hold on idle cycles, zero data on range error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (bus.data_sram_en) begin
            if (w_mmio_hit) begin
                r_rdata <= w_mmio_rdata;
                r_err   <= 1'b0;
            end else if (w_in_range) begin
                r_rdata <= w_merged;
                r_err   <= 1'b0;
            end else begin
                r_rdata <= 32'd0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.data_sram_rdata = r_rdata;
    assign bus.data_sram_err   = r_err;
endmodule
